// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared register-file constants for the write-back arbitration slice.
//   DW          : data word width
//   AW          : register index width
//   NREGS       : number of implemented registers (indices 0..NREGS-1)
//   REG_INVALID : index that names no register; writes and claims to it
//                 are dropped
//   rr_prio_e   : which requester the two-way round-robin favours next
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NREGS = 15;

    localparam logic [AW-1:0] REG_INVALID = 4'hF;

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } rr_prio_e;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Grants are purely combinational from the
// valids and the priority pointer; the pointer moves only when a grant is
// issued, so the requester not granted most recently wins a tie.
//   clk_i      : rising-edge clock
//   rst_i      : synchronous active-high reset; suppresses grants while high
//   valid0_i   : requester 0 valid
//   valid1_i   : requester 1 valid
//   grant0_o   : requester 0 granted this cycle
//   grant1_o   : requester 1 granted this cycle
// ----------------------------------------------------------------------------
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o
);

    rr_prio_e prio_q;
    rr_prio_e prio_d;

    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        if (!rst_i) begin
            if (valid0_i && (!valid1_i || prio_q == PRIO_REQ0)) begin
                grant0_o = 1'b1;
            end else if (valid1_i) begin
                grant1_o = 1'b1;
            end
        end
    end

    // After serving one side, the other side gets the next tie.
    always_comb begin
        prio_d = prio_q;
        if (grant0_o) begin
            prio_d = PRIO_REQ1;
        end else if (grant1_o) begin
            prio_d = PRIO_REQ0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= PRIO_REQ0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter
// Merges two register write-back sources (pipeline write-back on port 0,
// multi-cycle unit on port 1) onto a single registered register-file write
// port, and tracks which registers have an outstanding write (scoreboard).
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_valid/dest/value       : write request from source N
//   reqN_ready                  : request N transferred at this edge
//   claim_en, claim_dest        : mark claim_dest pending at instruction issue
//   src1/src2, src1_busy/src2_busy : combinational pending-write lookups
//   wb_en, wb_dest, wb_value    : registered register-file write port
//   claim_err                   : pulse after a claim to an already pending
//                                 register
// ----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DW    = regfile_pkg::DW,
    parameter int AW    = regfile_pkg::AW,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_dest,
    input  logic [DW-1:0] req0_value,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_dest,
    input  logic [DW-1:0] req1_value,
    output logic          req1_ready,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_dest,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] src2,
    output logic          src1_busy,
    output logic          src2_busy,
    output logic          wb_en,
    output logic [AW-1:0] wb_dest,
    output logic [DW-1:0] wb_value,
    output logic          claim_err
);

    import regfile_pkg::*;

    localparam logic [AW-1:0] INV_IDX = AW'(REG_INVALID);

    logic             xfer;
    logic [AW-1:0]    xfer_dest;
    logic [DW-1:0]    xfer_value;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] src1_sel;
    logic [NREGS-1:0] src2_sel;

    logic [NREGS-1:0] busy_q,      busy_d;
    logic             wb_en_q,     wb_en_d;
    logic [AW-1:0]    wb_dest_q,   wb_dest_d;
    logic [DW-1:0]    wb_value_q,  wb_value_d;
    logic             claim_err_q, claim_err_d;

    rr_arb2 u_arb (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .grant0_o (req0_ready),
        .grant1_o (req1_ready)
    );

    assign xfer       = req0_ready | req1_ready;
    assign xfer_dest  = req1_ready ? req1_dest  : req0_dest;
    assign xfer_value = req1_ready ? req1_value : req0_value;

    // One-hot decodes; the invalid index never matches any bit.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        src1_sel = '0;
        src2_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            clr_mask[i] = xfer     && (xfer_dest  == AW'(i));
            set_mask[i] = claim_en && (claim_dest == AW'(i));
            src1_sel[i] = (src1 == AW'(i));
            src2_sel[i] = (src2 == AW'(i));
        end
    end

    assign src1_busy = |(busy_q & src1_sel);
    assign src2_busy = |(busy_q & src2_sel);

    always_comb begin
        // Clear first, then set, so a same-edge claim keeps the register busy.
        busy_d      = (busy_q & ~clr_mask) | set_mask;
        // A claim colliding with a same-edge retire is a legal reuse, not an error.
        claim_err_d = |(set_mask & busy_q & ~clr_mask);
        wb_en_d     = xfer && (xfer_dest != INV_IDX)
                           && ({{(32-AW){1'b0}}, xfer_dest} < NREGS);
        wb_dest_d   = xfer ? xfer_dest  : wb_dest_q;
        wb_value_d  = xfer ? xfer_value : wb_value_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            wb_en_q     <= 1'b0;
            wb_dest_q   <= '0;
            wb_value_q  <= '0;
            claim_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            wb_en_q     <= wb_en_d;
            wb_dest_q   <= wb_dest_d;
            wb_value_q  <= wb_value_d;
            claim_err_q <= claim_err_d;
        end
    end

    assign wb_en     = wb_en_q;
    assign wb_dest   = wb_dest_q;
    assign wb_value  = wb_value_q;
    assign claim_err = claim_err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Randomised and directed stimulus against a behavioural model. The driver
// predicts grants and pending-register state, and queues the expected
// write-port and claim-error events; a separate monitor pops and compares
// them every cycle.
// ----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_dest,  req1_dest;
    logic [DW-1:0] req0_value, req1_value;
    logic          req0_ready, req1_ready;
    logic          claim_en;
    logic [AW-1:0] claim_dest, src1, src2;
    logic          src1_busy, src2_busy;
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_value;
    logic          claim_err;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_dest  (req0_dest),
        .req0_value (req0_value),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dest  (req1_dest),
        .req1_value (req1_value),
        .req1_ready (req1_ready),
        .claim_en   (claim_en),
        .claim_dest (claim_dest),
        .src1       (src1),
        .src2       (src2),
        .src1_busy  (src1_busy),
        .src2_busy  (src2_busy),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .claim_err  (claim_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Stimulus state: pending requests are held until granted.
    bit          v[2];
    logic [3:0]  d[2];
    logic [31:0] val[2];
    bit          rst_v;
    bit          ce;
    logic [3:0]  cd, s1, s2;

    // Reference model: who was served last, and which registers are pending.
    int last_g;
    bit mb[16];

    typedef struct {
        int          cyc;
        logic [3:0]  dest;
        logic [31:0] value;
    } wb_t;

    wb_t wbq[$];
    int  errq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model.
    task automatic step();
        int g;
        bool_dummy: begin end
        @(negedge clk);
        rst        = rst_v;
        req0_valid = v[0];
        req0_dest  = d[0];
        req0_value = val[0];
        req1_valid = v[1];
        req1_dest  = d[1];
        req1_value = val[1];
        claim_en   = ce;
        claim_dest = cd;
        src1       = s1;
        src2       = s2;
        #1;
        g = -1;
        if (!rst_v) begin
            if (v[0] && v[1]) g = (last_g == 0) ? 1 : 0;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
        end
        chk("req0_ready", 64'(req0_ready), 64'(g == 0));
        chk("req1_ready", 64'(req1_ready), 64'(g == 1));
        chk("src1_busy",  64'(src1_busy),  64'(mb[s1]));
        chk("src2_busy",  64'(src2_busy),  64'(mb[s2]));
        if (rst_v) begin
            for (int i = 0; i < 16; i++) mb[i] = 1'b0;
            last_g = 1;
        end else begin
            if (ce && cd != 4'hF && mb[cd] && !(g >= 0 && d[g] == cd))
                errq.push_back(cyc + 1);
            if (g >= 0) begin
                last_g = g;
                if (d[g] != 4'hF) begin
                    wbq.push_back('{cyc + 1, d[g], val[g]});
                    mb[d[g]] = 1'b0;
                end
                v[g] = 1'b0;
            end
            if (ce && cd != 4'hF) mb[cd] = 1'b1;
        end
        ce = 1'b0;
    endtask

    // Monitor: compares the registered outputs against queued expectations.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (wbq.size() > 0 && wbq[0].cyc == cyc) begin
                e = wbq.pop_front();
                chk("wb_en",    64'(wb_en),    64'(1));
                chk("wb_dest",  64'(wb_dest),  64'(e.dest));
                chk("wb_value", 64'(wb_value), 64'(e.value));
            end else begin
                chk("wb_en_idle", 64'(wb_en), 64'(0));
            end
            if (errq.size() > 0 && errq[0] == cyc) begin
                void'(errq.pop_front());
                chk("claim_err", 64'(claim_err), 64'(1));
            end else begin
                chk("claim_err_idle", 64'(claim_err), 64'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_dest = '0; req1_dest = '0; req0_value = '0; req1_value = '0;
        claim_en = 1'b0; claim_dest = '0; src1 = '0; src2 = '0;
        v[0] = 0; v[1] = 0; d[0] = 0; d[1] = 0; val[0] = 0; val[1] = 0;
        ce = 0; cd = 0; s1 = 0; s2 = 0; last_g = 1;
        for (int i = 0; i < 16; i++) mb[i] = 1'b0;

        // Reset state
        rst_v = 1;
        repeat (3) step();
        chk("rst_wb_dest",  64'(wb_dest),  64'(0));
        chk("rst_wb_value", 64'(wb_value), 64'(0));
        rst_v = 0;

        // Single request from port 0
        v[0] = 1; d[0] = 3; val[0] = 32'hDEAD;
        step();
        step();

        // Continuous contention after reset: alternate 0,1,0,1
        rst_v = 1; step(); rst_v = 0;
        for (int k = 0; k < 4; k++) begin
            if (!v[0]) begin v[0] = 1; d[0] = 1; val[0] = $urandom; end
            if (!v[1]) begin v[1] = 1; d[1] = 2; val[1] = $urandom; end
            step();
        end
        v[0] = 0; v[1] = 0;
        step();

        // Claim 5, retire it through port 1
        ce = 1; cd = 5; s1 = 5; step();
        v[1] = 1; d[1] = 5; val[1] = 32'h5555_0005; step();
        step();
        step();

        // Same-edge claim and retire of 7, then a lone claim of 7
        ce = 1; cd = 7; s1 = 7; step();
        ce = 1; cd = 7; v[0] = 1; d[0] = 7; val[0] = 32'h7777_0007; step();
        ce = 1; cd = 7; step();
        step();
        step();

        // Invalid destination is accepted but never written
        v[0] = 1; d[0] = 4'hF; val[0] = 32'hBAD0_000F; step();
        v[0] = 1; d[0] = 6; val[0] = 32'h6;
        v[1] = 1; d[1] = 8; val[1] = 32'h8; step();
        step();
        step();

        // Reset in the middle of activity
        ce = 1; cd = 4; s1 = 4; step();
        v[0] = 1; d[0] = 9;  val[0] = 32'h9;
        v[1] = 1; d[1] = 10; val[1] = 32'hA;
        rst_v = 1; step(); step(); rst_v = 0;
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            s1 = 4'(2 * k); s2 = 4'(2 * k + 1);
            step();
        end

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && $urandom_range(0, 99) < 60) begin
                    v[i]   = 1;
                    d[i]   = 4'($urandom_range(0, 15));
                    val[i] = $urandom;
                end
            end
            ce    = ($urandom_range(0, 99) < 35);
            cd    = 4'($urandom_range(0, 15));
            s1    = 4'($urandom_range(0, 15));
            s2    = 4'($urandom_range(0, 15));
            rst_v = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_v = 0;

        // Drain
        v[0] = 0; v[1] = 0;
        repeat (4) step();
        chk("wbq_drained",  64'(wbq.size()),  64'(0));
        chk("errq_drained", 64'(errq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter AW, default 4, register index width.
REQ-003 SHALL have parameter NREGS, default 15, implemented registers (indices 0..14); index 15 is invalid.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1  write request valid (0 = pipeline write-back, 1 = multi-cycle unit).
REQ-007 SHALL have ports req0_dest/req1_dest  input  AW  destination register.
REQ-008 SHALL have ports req0_value/req1_value  input  DW  write data.
REQ-009 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-010 SHALL have ports claim_en  input  1, claim_dest  input  AW  mark a register pending at instruction issue.
REQ-011 SHALL have ports src1/src2  input  AW, src1_busy/src2_busy  output  1  combinational pending-write flags.
REQ-012 SHALL have ports wb_en  output  1, wb_dest  output  AW, wb_value  output  DW  registered register-file write port.
REQ-013 SHALL have port claim_err  output  1  one-cycle pulse on claim of an already-pending register.

Function
REQ-014 SHALL transfer request i on a rising edge where reqi_valid && reqi_ready.
REQ-015 SHALL assert at most one ready per cycle; readiness combinational from valids and the round-robin pointer, no dependence on ready inputs.
REQ-016 SHALL grant the sole valid requester; with both valid, SHALL grant the requester not granted most recently.
REQ-017 SHALL update the round-robin pointer only on a transfer.
REQ-018 SHALL load wb_dest/wb_value from the transferred request and assert wb_en for exactly the following cycle (latency 1, throughput 1 per cycle).
REQ-019 SHALL drive wb_en=0 in any cycle following no transfer; wb_dest/wb_value hold their last values.
REQ-020 SHALL accept a request with dest 15 (ready asserted, pointer updated) but never assert wb_en for it.
REQ-021 SHALL maintain a NREGS-bit busy vector: claim_en sets busy[claim_dest] at the edge; a transfer clears busy[dest] at the same edge wb_dest is loaded.
REQ-022 SHALL, on simultaneous set and clear of the same register, leave busy set (set wins).
REQ-023 SHALL ignore claims to index 15; srcN_busy SHALL be 0 for srcN=15.
REQ-024 SHALL pulse claim_err the cycle after claim_en to a register already busy and not being cleared that edge; busy stays set.
REQ-025 SHALL require requesters to hold valid/dest/value stable until ready; behaviour otherwise undefined.

Reset
REQ-026 SHALL, while rst is high at a rising edge, clear busy, wb_en, wb_dest, wb_value, claim_err to 0 and set the pointer to favour requester 0.
REQ-027 SHALL hold req0_ready/req1_ready at 0 while rst is high; requests pending during reset are not transferred and claims are discarded.
REQ-028 SHALL resume arbitration on the first edge after rst falls.

Structure
REQ-029 SHALL take DW, AW, NREGS and REG_INVALID (4'hF) from a shared package regfile_pkg.
REQ-030 SHALL instantiate one sub-module rr_arb2 (two-way round-robin grant and pointer).

Verification
REQ-031 Single: req0 valid dest 3 value 0xDEAD -> req0_ready same cycle; next cycle wb_en=1, wb_dest=3, wb_value=0xDEAD.
REQ-032 Contention: both valid continuously after reset (dest 1 / dest 2) -> grants 0,1,0,1; wb_dest 1,2,1,2 with wb_en high every cycle.
REQ-033 Scoreboard: claim 5; src1=5 -> src1_busy=1; req1 dest 5 transferred -> src1_busy=0 the cycle wb_en=1.
REQ-034 Same-edge: busy[7] set, claim 7 with transfer to dest 7 -> busy[7] stays 1, claim_err=0; lone claim 7 again -> claim_err pulses 1.
REQ-035 Invalid: req0 dest 15 -> ready=1, wb_en stays 0, pointer favours req1 next.
REQ-036 Reset mid-operation: rst high while both valid and busy[4] set -> readys 0, wb_en=0, busy all 0; after release req0 granted first.
